mesh_top_x_y: RTL and testbench

Top level of the synchronous mesh network-on-chip without diagonal links. It instantiates a MESH_SIDE × MESH_SIDE grid of 5-port routers and wires each router to its orthogonal neighbours. Routing is dimension-ordered: X first, then Y. Every router port slot appears on the top-level interface arrays; traffic is normally injected and ejected on the LOCAL ports.

---
 rtl/mesh_top_x_y.sv | 233 +++++++++++++++++++++++
 tb/tb_mesh_top_x_y.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_top_x_y.sv
//==============================================================================
// Module   : mesh_top_x_y
// Brief    : MESH_SIDE x MESH_SIDE mesh NoC of 5-port XY-routed routers.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package global_params;
  localparam int NORTH     = 0;
  localparam int EAST      = 1;
  localparam int SOUTH     = 2;
  localparam int WEST      = 3;
  localparam int LOCAL     = 4;
  localparam int NUM_PORTS = 5;
endpackage

module mesh_router
  import global_params::*;
#(
  parameter int X  = 0,
  parameter int Y  = 0,
  parameter int CW = 2,
  parameter int DW = 32,
  localparam int FW = 2 + 2 * CW + DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_in_valid  [NUM_PORTS],
  input  logic [FW-1:0] i_in_flit   [NUM_PORTS],
  output logic          o_in_ready  [NUM_PORTS],
  output logic          o_out_valid [NUM_PORTS],
  output logic [FW-1:0] o_out_flit  [NUM_PORTS],
  input  logic          i_out_ready [NUM_PORTS]
);

  localparam logic [CW-1:0] c_x = CW'(X);
  localparam logic [CW-1:0] c_y = CW'(Y);

  logic          r_slot_valid [NUM_PORTS];
  logic [FW-1:0] r_slot_flit  [NUM_PORTS];
  logic          r_out_valid  [NUM_PORTS];
  logic [FW-1:0] r_out_flit   [NUM_PORTS];
  logic [2:0]    r_ptr        [NUM_PORTS];
  logic [2:0]    w_dir        [NUM_PORTS];
  logic          w_req        [NUM_PORTS][NUM_PORTS];
  logic          w_gnt        [NUM_PORTS];
  logic [2:0]    w_win        [NUM_PORTS];
  logic          w_take       [NUM_PORTS];

  function automatic logic [2:0] route(input logic [FW-1:0] f);
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    dx = f[DW+2*CW-1 -: CW];
    dy = f[DW+CW-1 -: CW];
    if (dx > c_x)      return 3'(EAST);
    else if (dx < c_x) return 3'(WEST);
    else if (dy > c_y) return 3'(NORTH);
    else if (dy < c_y) return 3'(SOUTH);
    else               return 3'(LOCAL);
  endfunction

  function automatic logic [2:0] wrap5(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_dir[p] = route(r_slot_flit[p]);
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_req[o][p] = r_slot_valid[p] && (w_dir[p] == 3'(o));
      end
    end
  end

  // Scan from the lowest priority upward so the last hit is the one nearest the pointer.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) w_take[p] = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_gnt[o] = 1'b0;
      w_win[o] = 3'd0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (w_req[o][wrap5(r_ptr[o], 3'(k))]) begin
          w_gnt[o] = 1'b1;
          w_win[o] = wrap5(r_ptr[o], 3'(k));
        end
      end
      if (r_out_valid[o] && !i_out_ready[o]) w_gnt[o] = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_gnt[o] && (w_win[o] == 3'(p))) w_take[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_slot_valid[p] <= 1'b0;
        r_slot_flit[p]  <= '0;
        r_out_valid[p]  <= 1'b0;
        r_out_flit[p]   <= '0;
        r_ptr[p]        <= 3'(NORTH);
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_take[p]) begin
          r_slot_valid[p] <= 1'b0;
        end else if (i_in_valid[p] && !r_slot_valid[p]) begin
          r_slot_valid[p] <= 1'b1;
          r_slot_flit[p]  <= i_in_flit[p];
        end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt[o]) begin
          r_out_valid[o] <= 1'b1;
          r_out_flit[o]  <= r_slot_flit[w_win[o]];
          r_ptr[o]       <= wrap5(w_win[o], 3'd1);
        end else if (i_out_ready[o]) begin
          r_out_valid[o] <= 1'b0;
          r_out_flit[o]  <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_in_ready[p]  = !r_slot_valid[p];
      o_out_valid[p] = r_out_valid[p];
      o_out_flit[p]  = r_out_flit[p];
    end
  end

endmodule

module mesh_top_x_y
  import global_params::*;
#(
  parameter int MESH_SIDE  = 4,
  parameter int DATA_WIDTH = 32,
  localparam int CW = $clog2(MESH_SIDE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_in_s_delta_x  [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  input  logic                  r_in_s_delta_y  [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  input  logic [CW-1:0]         r_in_dest_x     [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  input  logic [CW-1:0]         r_in_dest_y     [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  input  logic [DATA_WIDTH-1:0] r_in_data       [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  input  logic                  r_in_valid      [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  output logic                  r_in_ready      [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  output logic                  r_out_s_delta_x [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  output logic                  r_out_s_delta_y [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  output logic [CW-1:0]         r_out_dest_x    [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  output logic [CW-1:0]         r_out_dest_y    [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  output logic [DATA_WIDTH-1:0] r_out_data      [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  output logic                  r_out_valid     [MESH_SIDE][MESH_SIDE][NUM_PORTS],
  input  logic                  r_out_ready     [MESH_SIDE][MESH_SIDE][NUM_PORTS]
);

  localparam int FW = 2 + 2 * CW + DATA_WIDTH;

  logic          w_in_valid  [MESH_SIDE][MESH_SIDE][NUM_PORTS];
  logic [FW-1:0] w_in_flit   [MESH_SIDE][MESH_SIDE][NUM_PORTS];
  logic          w_in_ready  [MESH_SIDE][MESH_SIDE][NUM_PORTS];
  logic          w_out_valid [MESH_SIDE][MESH_SIDE][NUM_PORTS];
  logic [FW-1:0] w_out_flit  [MESH_SIDE][MESH_SIDE][NUM_PORTS];
  logic          w_out_ready [MESH_SIDE][MESH_SIDE][NUM_PORTS];

  for (genvar i = 0; i < MESH_SIDE; i++) begin : g_x
    for (genvar j = 0; j < MESH_SIDE; j++) begin : g_y
      mesh_router #(
        .X  (i),
        .Y  (j),
        .CW (CW),
        .DW (DATA_WIDTH)
      ) u_router (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (w_in_valid[i][j]),
        .i_in_flit   (w_in_flit[i][j]),
        .o_in_ready  (w_in_ready[i][j]),
        .o_out_valid (w_out_valid[i][j]),
        .o_out_flit  (w_out_flit[i][j]),
        .i_out_ready (w_out_ready[i][j])
      );

      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam bit HAS_NB = (p == NORTH && j < MESH_SIDE - 1) ||
                                (p == EAST  && i < MESH_SIDE - 1) ||
                                (p == SOUTH && j > 0) ||
                                (p == WEST  && i > 0);
        localparam int NI  = (p == EAST) ? i + 1 : (p == WEST) ? i - 1 : i;
        localparam int NJ  = (p == NORTH) ? j + 1 : (p == SOUTH) ? j - 1 : j;
        localparam int OPP = (p + 2) % 4;

        if (HAS_NB) begin : g_link
          // Neighbour's facing output feeds this slot; this output feeds its facing slot.
          assign w_in_valid[i][j][p]      = w_out_valid[NI][NJ][OPP];
          assign w_in_flit[i][j][p]       = w_out_flit[NI][NJ][OPP];
          assign w_out_ready[i][j][p]     = w_in_ready[NI][NJ][OPP];
          assign r_in_ready[i][j][p]      = 1'b0;
          assign r_out_valid[i][j][p]     = 1'b0;
          assign r_out_s_delta_x[i][j][p] = 1'b0;
          assign r_out_s_delta_y[i][j][p] = 1'b0;
          assign r_out_dest_x[i][j][p]    = '0;
          assign r_out_dest_y[i][j][p]    = '0;
          assign r_out_data[i][j][p]      = '0;
        end else begin : g_ext
          assign w_in_valid[i][j][p]      = r_in_valid[i][j][p];
          assign w_in_flit[i][j][p]       = {r_in_s_delta_x[i][j][p], r_in_s_delta_y[i][j][p],
                                             r_in_dest_x[i][j][p], r_in_dest_y[i][j][p],
                                             r_in_data[i][j][p]};
          assign r_in_ready[i][j][p]      = w_in_ready[i][j][p];
          assign w_out_ready[i][j][p]     = r_out_ready[i][j][p];
          assign r_out_valid[i][j][p]     = w_out_valid[i][j][p];
          assign r_out_s_delta_x[i][j][p] = w_out_flit[i][j][p][FW-1];
          assign r_out_s_delta_y[i][j][p] = w_out_flit[i][j][p][FW-2];
          assign r_out_dest_x[i][j][p]    = w_out_flit[i][j][p][DATA_WIDTH+2*CW-1 -: CW];
          assign r_out_dest_y[i][j][p]    = w_out_flit[i][j][p][DATA_WIDTH+CW-1 -: CW];
          assign r_out_data[i][j][p]      = w_out_flit[i][j][p][DATA_WIDTH-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mesh_top_x_y.sv
//==============================================================================
// Module   : tb_mesh_top_x_y
// Brief    : Directed and random-traffic self-checking bench for mesh_top_x_y.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mesh_top_x_y;

  localparam int S  = 4;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int L  = 4;
  localparam int NP = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          in_sdx   [S][S][NP];
  logic          in_sdy   [S][S][NP];
  logic [CW-1:0] in_dx    [S][S][NP];
  logic [CW-1:0] in_dy    [S][S][NP];
  logic [DW-1:0] in_data  [S][S][NP];
  logic          in_valid [S][S][NP];
  logic          in_ready [S][S][NP];
  logic          out_sdx  [S][S][NP];
  logic          out_sdy  [S][S][NP];
  logic [CW-1:0] out_dx   [S][S][NP];
  logic [CW-1:0] out_dy   [S][S][NP];
  logic [DW-1:0] out_data [S][S][NP];
  logic          out_valid[S][S][NP];
  logic          out_ready[S][S][NP];

  int n_checks = 0;
  int n_fail   = 0;

  int sb_dx [4096];
  int sb_dy [4096];
  int sb_sdx[4096];
  int sb_sdy[4096];
  int sb_got[4096];
  int n_inj = 0;
  int n_del = 0;

  mesh_top_x_y #(.MESH_SIDE(S), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .r_in_s_delta_x  (in_sdx),
    .r_in_s_delta_y  (in_sdy),
    .r_in_dest_x     (in_dx),
    .r_in_dest_y     (in_dy),
    .r_in_data       (in_data),
    .r_in_valid      (in_valid),
    .r_in_ready      (in_ready),
    .r_out_s_delta_x (out_sdx),
    .r_out_s_delta_y (out_sdy),
    .r_out_dest_x    (out_dx),
    .r_out_dest_y    (out_dy),
    .r_out_data      (out_data),
    .r_out_valid     (out_valid),
    .r_out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit has_nb(input int i, input int j, input int p);
    case (p)
      0:       return j < S - 1;
      1:       return i < S - 1;
      2:       return j > 0;
      3:       return i > 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int local_cnt();
    int c = 0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        if (out_valid[i][j][L]) c++;
    return c;
  endfunction

  function automatic int nonlocal_valid_cnt();
    int c = 0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        for (int p = 0; p < L; p++)
          if (out_valid[i][j][p]) c++;
    return c;
  endfunction

  task automatic drive(input int i, input int j, input int dx, input int dy,
                       input logic sx, input logic sy, input logic [DW-1:0] d);
    in_valid[i][j][L] = 1'b1;
    in_sdx[i][j][L]   = sx;
    in_sdy[i][j][L]   = sy;
    in_dx[i][j][L]    = CW'(dx);
    in_dy[i][j][L]    = CW'(dy);
    in_data[i][j][L]  = d;
  endtask

  task automatic clear_in();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        for (int p = 0; p < NP; p++)
          in_valid[i][j][p] = 1'b0;
  endtask

  initial begin
    int cnt;
    int ok_cnt;
    int bad_cnt;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        for (int p = 0; p < NP; p++) begin
          in_sdx[i][j][p]    = 1'b0;
          in_sdy[i][j][p]    = 1'b0;
          in_dx[i][j][p]     = '0;
          in_dy[i][j][p]     = '0;
          in_data[i][j][p]   = '0;
          in_valid[i][j][p]  = 1'b0;
          out_ready[i][j][p] = 1'b1;
        end

    // Reset: outputs all zero while held.
    step(3);
    cnt = 0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        for (int p = 0; p < NP; p++)
          if (out_valid[i][j][p] || out_sdx[i][j][p] || out_sdy[i][j][p] ||
              out_dx[i][j][p] != 0 || out_dy[i][j][p] != 0 || out_data[i][j][p] != 0) cnt++;
    chk("rst_out_zero", cnt, 0);

    rst = 1'b1;
    step(1);
    ok_cnt  = 0;
    bad_cnt = 0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        for (int p = 0; p < NP; p++) begin
          if (has_nb(i, j, p)) begin
            if (in_ready[i][j][p] !== 1'b0) bad_cnt++;
          end else if (in_ready[i][j][p] === 1'b1) ok_cnt++;
        end
    chk("rst_active_ready", ok_cnt, 32);
    chk("rst_link_ready0", bad_cnt, 0);

    // Self-delivery at (0,0).
    drive(0, 0, 0, 0, 1'b1, 1'b1, 32'h0000_00AB);
    step(1);
    clear_in();
    chk("self_t0_valid", out_valid[0][0][L], 0);
    step(1);
    chk("self_valid", out_valid[0][0][L], 1);
    chk("self_data", out_data[0][0][L], 32'hAB);
    chk("self_dest", {out_dx[0][0][L], out_dy[0][0][L]}, 0);
    chk("self_side", {out_sdx[0][0][L], out_sdy[0][0][L]}, 2'b11);
    step(1);
    chk("self_consumed", out_valid[0][0][L], 0);

    // Multi-hop (0,0) -> (3,2): 5 hops, arrival after edge t+11.
    drive(0, 0, 3, 2, 1'b0, 1'b0, 32'h0000_0123);
    step(1);
    clear_in();
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("hop_local_cnt", local_cnt(), (k == 11) ? 1 : 0);
      if (k == 11) begin
        chk("hop_arrive", out_valid[3][2][L], 1);
        chk("hop_data", out_data[3][2][L], 32'h123);
        chk("hop_dest", {out_dx[3][2][L], out_dy[3][2][L]}, {2'd3, 2'd2});
      end
    end

    // Contention at (1,1): EAST slot wins first from pointer NORTH.
    drive(0, 1, 1, 1, 1'b0, 1'b1, 32'hC0DE_0001);
    drive(2, 1, 1, 1, 1'b1, 1'b0, 32'hC0DE_0002);
    step(1);
    clear_in();
    step(2);
    chk("cont_early", out_valid[1][1][L], 0);
    step(1);
    chk("cont_first_valid", out_valid[1][1][L], 1);
    chk("cont_first_data", out_data[1][1][L], 32'hC0DE_0002);
    chk("cont_first_side", {out_sdx[1][1][L], out_sdy[1][1][L]}, 2'b10);
    step(1);
    chk("cont_second_valid", out_valid[1][1][L], 1);
    chk("cont_second_data", out_data[1][1][L], 32'hC0DE_0001);
    chk("cont_second_side", {out_sdx[1][1][L], out_sdy[1][1][L]}, 2'b01);
    step(1);
    chk("cont_done", out_valid[1][1][L], 0);

    // Backpressure at (3,3) LOCAL.
    out_ready[3][3][L] = 1'b0;
    drive(3, 3, 3, 3, 1'b0, 1'b0, 32'hB000_0001);
    step(1);
    clear_in();
    step(1);
    chk("bp_f1_valid", out_valid[3][3][L], 1);
    chk("bp_f1_data", out_data[3][3][L], 32'hB000_0001);
    chk("bp_in_ready1", in_ready[3][3][L], 1);
    drive(3, 3, 3, 3, 1'b1, 1'b0, 32'hB000_0002);
    step(1);
    clear_in();
    chk("bp_in_ready0", in_ready[3][3][L], 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("bp_hold_valid", out_valid[3][3][L], 1);
      chk("bp_hold_data", out_data[3][3][L], 32'hB000_0001);
      chk("bp_hold_ready", in_ready[3][3][L], 0);
    end
    out_ready[3][3][L] = 1'b1;
    step(1);
    chk("bp_f2_valid", out_valid[3][3][L], 1);
    chk("bp_f2_data", out_data[3][3][L], 32'hB000_0002);
    chk("bp_f2_side", out_sdx[3][3][L], 1);
    chk("bp_ready_back", in_ready[3][3][L], 1);
    step(1);
    chk("bp_drained", out_valid[3][3][L], 0);

    // Random traffic: 20% per LOCAL for 200 cycles, then drain.
    for (int s = 0; s < 4096; s++) sb_got[s] = 0;
    for (int cyc = 0; cyc < 500 && (cyc < 200 || n_del < n_inj); cyc++) begin
      step(1);
      chk("rand_edge_valid", nonlocal_valid_cnt(), 0);
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++)
          if (out_valid[i][j][L]) begin
            int seq;
            seq = int'(out_data[i][j][L][15:0]);
            chk("rand_known", (seq < n_inj), 1);
            if (seq < n_inj) begin
              chk("rand_dest", {i[7:0], j[7:0]}, {sb_dx[seq][7:0], sb_dy[seq][7:0]});
              chk("rand_src", out_data[i][j][L][31:16], {sb_sdx[seq][7:0], sb_sdy[seq][7:0]});
              chk("rand_once", sb_got[seq], 0);
              if (sb_got[seq] == 0) n_del++;
              sb_got[seq] = 1;
            end
          end
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          in_valid[i][j][L] = 1'b0;
          if (cyc < 200 && in_ready[i][j][L] && $urandom_range(0, 99) < 20) begin
            int dx;
            int dy;
            dx = int'($urandom_range(0, S - 1));
            dy = int'($urandom_range(0, S - 1));
            sb_dx[n_inj]  = dx;
            sb_dy[n_inj]  = dy;
            sb_sdx[n_inj] = i;
            sb_sdy[n_inj] = j;
            drive(i, j, dx, dy, 1'(n_inj), 1'(n_inj >> 1),
                  {8'(i), 8'(j), 16'(n_inj)});
            n_inj++;
          end
        end
    end
    clear_in();
    chk("rand_all_delivered", n_del, n_inj);
    chk("rand_some_traffic", (n_inj > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
